// File: rtl/skewt_pkg.sv
// Shared types for the skew tent map blocks.
// Build option: SKEWT_ROUND_EN adds a guard quotient bit so the map result
// is rounded to nearest instead of truncated.
package skewt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_DIV      = 2'd2,
        ST_OUT      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CASE_A = 2'd0,  // 0 < x < p : x / p
        CASE_B = 2'd1,  // x > p     : (1-x) / (1-p)
        CASE_C = 2'd2   // x == 0 or x == p : all-ones, no division
    } case_e;

`ifdef SKEWT_ROUND_EN
    localparam int unsigned DIV_GUARD = 1;
`else
    localparam int unsigned DIV_GUARD = 0;
`endif

    // Quotient bits produced (and cycles spent) by the divider for width w.
    function automatic int unsigned div_cycles(input int unsigned w);
        return w + DIV_GUARD;
    endfunction

endpackage

// File: rtl/skewt_div_serial.sv
// Restoring radix-2 serial divider: quotient of (dividend * 2^QW) / divisor,
// one quotient bit per cycle. Requires dividend < divisor <= 2^W, so the
// partial remainder always fits in W bits and the quotient in QW bits.
// The first quotient bit is resolved on the start edge itself, so o_done
// is visible QW-1 cycles after the start edge.
module skewt_div_serial #(
    parameter int unsigned W  = 32,
    parameter int unsigned QW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic [W-1:0]  i_dividend,
    input  logic [W:0]    i_divisor,
    output logic          o_done,
    output logic [QW-1:0] o_q
);

    localparam int unsigned CW = $clog2(QW + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  rem_d;
    logic [W:0]    dvs_q;
    logic [QW-1:0] quo_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  rem_src;
    logic [W:0]    dvs_src;
    logic [W:0]    rem_sh;
    logic          q_bit;

    // One restoring step; on start it works from the fresh operands.
    always_comb begin
        rem_src = i_start ? i_dividend : rem_q;
        dvs_src = i_start ? i_divisor  : dvs_q;
        rem_sh  = {rem_src, 1'b0};
        q_bit   = (rem_sh >= dvs_src);
        // The true difference is below the divisor (<= 2^W), so W-bit
        // modular subtraction is exact.
        rem_d   = q_bit ? (rem_sh[W-1:0] - dvs_src[W-1:0]) : rem_sh[W-1:0];
    end

    // Step sequencing, quotient shift register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (i_clear) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (i_start) begin
            dvs_q  <= i_divisor;
            rem_q  <= rem_d;
            quo_q  <= {{(QW-1){1'b0}}, q_bit};
            cnt_q  <= CW'(QW - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[QW-2:0], q_bit};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign o_done = done_q;
    assign o_q    = quo_q;

endmodule

// File: rtl/skewt_map_iter.sv
// Iterating skew tent map engine with valid/ready output and abort.
// Build option: SKEWT_ROUND_EN selects round-to-nearest results (one extra
// divider cycle per A/B iterate); otherwise results are truncated.
module skewt_map_iter
    import skewt_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [W-1:0]     i_x0,
    input  logic [W-1:0]     i_p,
    input  logic [CNT_W-1:0] i_iters,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_x,
    output logic             o_last
);

    localparam int unsigned   QW    = div_cycles(W);
    localparam logic [W:0]    ONE_W = {1'b1, {W{1'b0}}};

    state_e           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     p_q, p_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [W-1:0]     res_q, res_d;

    case_e            cls;
    logic [W-1:0]     dividend;
    logic [W:0]       divisor;
    logic             div_start;
    logic             div_done;
    logic [QW-1:0]    div_q;
    logic [W-1:0]     div_res;

    // Pick the map branch and the divider operands for the current x.
    always_comb begin
        cls      = CASE_C;
        dividend = '0;
        divisor  = '0;
        if (x_q == '0 || x_q == p_q) begin
            cls = CASE_C;
        end else if (x_q < p_q) begin
            cls      = CASE_A;
            dividend = x_q;
            divisor  = {1'b0, p_q};
        end else begin
            cls      = CASE_B;
            dividend = ~x_q + W'(1);       // 2^W - x, x >= 1 here
            divisor  = ONE_W - {1'b0, p_q}; // p = 0 gives 2^W
        end
    end

    assign div_start = (state_q == ST_CLASSIFY) && (cls != CASE_C);

    skewt_div_serial #(
        .W  (W),
        .QW (QW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (div_start),
        .i_clear    (i_abort),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_done     (div_done),
        .o_q        (div_q)
    );

`ifdef SKEWT_ROUND_EN
    logic [W:0] rnd_sum;

    // Round on the guard bit, saturating if the increment carries out.
    always_comb begin
        rnd_sum = {1'b0, div_q[QW-1:1]} + {{W{1'b0}}, div_q[0]};
        div_res = rnd_sum[W] ? '1 : rnd_sum[W-1:0];
    end
`else
    assign div_res = div_q;
`endif

    // Next-state logic: iteration control, handshake, abort priority.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        iter_d  = iter_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    x_d     = i_x0;
                    p_d     = i_p;
                    iter_d  = (i_iters == '0) ? CNT_W'(1) : i_iters;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (cls == CASE_C) begin
                    res_d   = '1;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    res_d   = div_res;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (i_ready) begin
                    if (iter_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        x_d     = res_q;
                        iter_d  = iter_q - CNT_W'(1);
                        state_d = ST_CLASSIFY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            p_q     <= '0;
            iter_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
        end
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_valid = (state_q == ST_OUT);
    assign o_x     = o_valid ? res_q : '0;
    assign o_last  = o_valid && (iter_q == CNT_W'(1));

endmodule

// File: tb/tb_skewt_map_iter.sv
// Directed bench for skewt_map_iter: one W=8 instance for the scenario
// tests and one W=32 instance for wide-operand vectors.
module tb_skewt_map_iter;

`ifdef SKEWT_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif
    localparam int LAT8  = 8 + ROUND + 2;
    localparam int LAT32 = 32 + ROUND + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 0, abort8 = 0, ready8 = 0;
    logic [7:0]  x0_8 = '0, p8 = '0;
    logic [15:0] it8 = '0;
    logic        busy8, valid8, last8;
    logic [7:0]  x8;

    logic        start32 = 0, abort32 = 0, ready32 = 0;
    logic [31:0] x0_32 = '0, p32 = '0;
    logic [15:0] it32 = '0;
    logic        busy32, valid32, last32;
    logic [31:0] x32;

    int pass_cnt = 0;
    int total_cnt = 0;

    skewt_map_iter #(.W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start8), .i_abort(abort8),
        .i_x0(x0_8), .i_p(p8), .i_iters(it8), .o_busy(busy8),
        .o_valid(valid8), .i_ready(ready8), .o_x(x8), .o_last(last8)
    );

    skewt_map_iter #(.W(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_start(start32), .i_abort(abort32),
        .i_x0(x0_32), .i_p(p32), .i_iters(it32), .o_busy(busy32),
        .o_valid(valid32), .i_ready(ready32), .o_x(x32), .o_last(last32)
    );

    task automatic start_8(input logic [7:0] x0, input logic [7:0] p, input logic [15:0] n);
        @(negedge clk);
        x0_8 = x0; p8 = p; it8 = n; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Counts negedges (1 = first negedge after the accepting edge) until valid.
    task automatic wait_8(output int lat);
        lat = 1;
        while (!valid8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_8();
        ready8 = 1'b1;
        @(negedge clk);
        ready8 = 1'b0;
    endtask

    task automatic wait_32(output int lat);
        lat = 1;
        while (!valid32 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        total_cnt++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy8); else pass_cnt++;
        total_cnt++; if (valid8 !== 1'b0) $display("FAIL reset_valid got %b want 0", valid8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b0) $display("FAIL reset_last got %b want 0", last8); else pass_cnt++;
        total_cnt++; if (x8 !== 8'h00) $display("FAIL reset_x got %h want 00", x8); else pass_cnt++;
        total_cnt++; if (busy32 !== 1'b0 || valid32 !== 1'b0) $display("FAIL reset_32 got busy=%b valid=%b want 0 0", busy32, valid32); else pass_cnt++;
    endtask

    task automatic test_case_a();
        int lat;
        start_8(8'h40, 8'h80, 16'd1);
        total_cnt++; if (busy8 !== 1'b1) $display("FAIL a_busy_rise got %b want 1", busy8); else pass_cnt++;
        wait_8(lat);
        total_cnt++; if (lat != LAT8) $display("FAIL a_latency got %0d want %0d", lat, LAT8); else pass_cnt++;
        total_cnt++; if (x8 !== 8'h80) $display("FAIL a_value got %h want 80", x8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b1) $display("FAIL a_last got %b want 1", last8); else pass_cnt++;
        ack_8();
        total_cnt++; if (busy8 !== 1'b0 || valid8 !== 1'b0) $display("FAIL a_done got busy=%b valid=%b want 0 0", busy8, valid8); else pass_cnt++;
    endtask

    task automatic test_case_b_c();
        int lat;
        start_8(8'hC0, 8'h80, 16'd1);
        wait_8(lat);
        total_cnt++; if (lat != LAT8) $display("FAIL b_latency got %0d want %0d", lat, LAT8); else pass_cnt++;
        total_cnt++; if (x8 !== 8'h80) $display("FAIL b_value got %h want 80", x8); else pass_cnt++;
        ack_8();
        start_8(8'h00, 8'h80, 16'd0);
        wait_8(lat);
        total_cnt++; if (lat != 2) $display("FAIL c_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (x8 !== 8'hFF) $display("FAIL c_value got %h want ff", x8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b1) $display("FAIL c_iters0_last got %b want 1", last8); else pass_cnt++;
        ack_8();
        total_cnt++; if (busy8 !== 1'b0) $display("FAIL c_busy_fall got %b want 0", busy8); else pass_cnt++;
    endtask

    task automatic test_multi_iter();
        int lat;
        start_8(8'h40, 8'h80, 16'd3);
        wait_8(lat);
        total_cnt++; if (lat != LAT8 || x8 !== 8'h80) $display("FAIL it1 got lat=%0d x=%h want lat=%0d x=80", lat, x8, LAT8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b0) $display("FAIL it1_last got %b want 0", last8); else pass_cnt++;
        ack_8();
        wait_8(lat);
        total_cnt++; if (lat != 2 || x8 !== 8'hFF) $display("FAIL it2 got lat=%0d x=%h want lat=2 x=ff", lat, x8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b0) $display("FAIL it2_last got %b want 0", last8); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            x0_8 = 8'h10; p8 = 8'h20; it8 = 16'd1;
            start8 = (i == 1);
            @(negedge clk);
            total_cnt++; if (valid8 !== 1'b1 || x8 !== 8'hFF) $display("FAIL hold_%0d got valid=%b x=%h want 1 ff", i, valid8, x8); else pass_cnt++;
        end
        start8 = 1'b0;
        ack_8();
        total_cnt++; if (valid8 !== 1'b0) $display("FAIL valid_drop got %b want 0", valid8); else pass_cnt++;
        wait_8(lat);
        total_cnt++; if (lat != LAT8 || x8 !== 8'h02) $display("FAIL it3 got lat=%0d x=%h want lat=%0d x=02", lat, x8, LAT8); else pass_cnt++;
        total_cnt++; if (last8 !== 1'b1) $display("FAIL it3_last got %b want 1", last8); else pass_cnt++;
        ack_8();
        total_cnt++; if (busy8 !== 1'b0 || valid8 !== 1'b0) $display("FAIL multi_end got busy=%b valid=%b want 0 0", busy8, valid8); else pass_cnt++;
    endtask

    task automatic test_rounding();
        int lat;
        logic [7:0] exp23;
        exp23 = (ROUND != 0) ? 8'hAB : 8'hAA;
        start_8(8'd2, 8'd3, 16'd1);
        wait_8(lat);
        total_cnt++; if (lat != LAT8) $display("FAIL round_latency got %0d want %0d", lat, LAT8); else pass_cnt++;
        total_cnt++; if (x8 !== exp23) $display("FAIL round_2_3 got %h want %h", x8, exp23); else pass_cnt++;
        ack_8();
        start_8(8'd1, 8'd3, 16'd1);
        wait_8(lat);
        total_cnt++; if (x8 !== 8'h55) $display("FAIL round_1_3 got %h want 55", x8); else pass_cnt++;
        ack_8();
    endtask

    task automatic test_abort_reset();
        int lat;
        logic seen;
        start_8(8'h40, 8'h80, 16'd1);
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        total_cnt++; if (busy8 !== 1'b0 || valid8 !== 1'b0) $display("FAIL abort got busy=%b valid=%b want 0 0", busy8, valid8); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | valid8 | busy8;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL abort_quiet got %b want 0", seen); else pass_cnt++;
        start_8(8'hC0, 8'h80, 16'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({busy8, valid8, last8, x8} !== 11'd0) $display("FAIL reset_mid_div got busy=%b valid=%b last=%b x=%h want all 0", busy8, valid8, last8, x8); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | valid8 | busy8;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL reset_quiet got %b want 0", seen); else pass_cnt++;
        start_8(8'h40, 8'h80, 16'd1);
        wait_8(lat);
        total_cnt++; if (lat != LAT8 || x8 !== 8'h80) $display("FAIL restart got lat=%0d x=%h want lat=%0d x=80", lat, x8, LAT8); else pass_cnt++;
        ack_8();
    endtask

    task automatic test_w32();
        logic [31:0] vx [5];
        logic [31:0] vp [5];
        logic [31:0] ve [5];
        int          vn [5];
        int          lat;
        int          want_lat;
        vx[0] = 32'h4000_0000; vp[0] = 32'h8000_0000; ve[0] = 32'h8000_0000; vn[0] = 1;
        vx[1] = 32'h8000_0000; vp[1] = 32'h0000_0000; ve[1] = 32'h8000_0000; vn[1] = 2;
        vx[2] = 32'h1234_5678; vp[2] = 32'h1234_5678; ve[2] = 32'hFFFF_FFFF; vn[2] = 1;
        vx[3] = 32'hC000_0000; vp[3] = 32'h4000_0000; ve[3] = 32'h5555_5555; vn[3] = 1;
        vx[4] = 32'h8000_0000; vp[4] = 32'hC000_0000;
        ve[4] = (ROUND != 0) ? 32'hAAAA_AAAB : 32'hAAAA_AAAA; vn[4] = 1;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            x0_32 = vx[v]; p32 = vp[v]; it32 = 16'(vn[v]); start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            want_lat = (vx[v] == vp[v]) ? 2 : LAT32;
            for (int k = 0; k < vn[v]; k++) begin
                wait_32(lat);
                total_cnt++; if (lat != want_lat) $display("FAIL w32_lat_v%0d_i%0d got %0d want %0d", v, k, lat, want_lat); else pass_cnt++;
                total_cnt++; if (x32 !== ve[v]) $display("FAIL w32_x_v%0d_i%0d got %h want %h", v, k, x32, ve[v]); else pass_cnt++;
                total_cnt++; if (last32 !== (k == vn[v] - 1)) $display("FAIL w32_last_v%0d_i%0d got %b want %b", v, k, last32, (k == vn[v] - 1)); else pass_cnt++;
                ready32 = 1'b1;
                @(negedge clk);
                ready32 = 1'b0;
            end
        end
        total_cnt++; if (busy32 !== 1'b0) $display("FAIL w32_busy_end got %b want 0", busy32); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_case_a();
        test_case_b_c();
        test_multi_iter();
        test_rounding();
        test_abort_reset();
        test_w32();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
